// File: rtl/math_pkg.sv
// math_pkg: small integer helpers for the chunked arithmetic blocks
// (pipelined adder and subtractor). These are used at elaboration time to size
// pipelines and slices.
package math_pkg;

    // Integer division that rounds up. Gives the number of slices needed to cover a word.
    function automatic int ceil_division(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Smaller of two integers.
    function automatic int min(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    // Width of slice k. Every slice is CHUNK bits except a possibly narrower last one.
    function automatic int chunk_width(input int width, input int chunk, input int k);
        return min(chunk, width - k * chunk);
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// adder_chunk_stage: one slice of the chunked pipelined adder.
// The operand slice is delayed by PRE_DELAY cycles so it meets the carry from the
// previous slice. It is then added with that carry, and both sum and carry are
// registered. The sum is delayed a further POST_DELAY cycles so every slice of a
// word reaches the output on the same cycle.
// With PIPELINED_ADDER_OVERFLOW_EN defined, the stage also exports its
// combinational signed-overflow term (carry into MSB XOR carry out of MSB).
module adder_chunk_stage #(
    parameter int W          = 1,
    parameter int PRE_DELAY  = 0,
    parameter int POST_DELAY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic         signOvf_o
`endif
);

    logic [W-1:0] aDel;
    logic [W-1:0] bDel;
    logic [W:0]   sumFull_d;
    logic [W-1:0] sum_q;
    logic         carry_q;

    generate
        if (PRE_DELAY == 0) begin : g_noSkew
            assign aDel = a_i;
            assign bDel = b_i;
        end else begin : g_skew
            logic [W-1:0] aSkew_q [PRE_DELAY];
            logic [W-1:0] bSkew_q [PRE_DELAY];

            // Input skew: hold this slice back until the lower slices' carry arrives.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PRE_DELAY; i++) begin
                        aSkew_q[i] <= '0;
                        bSkew_q[i] <= '0;
                    end
                end else if (en) begin
                    aSkew_q[0] <= a_i;
                    bSkew_q[0] <= b_i;
                    for (int i = 1; i < PRE_DELAY; i++) begin
                        aSkew_q[i] <= aSkew_q[i-1];
                        bSkew_q[i] <= bSkew_q[i-1];
                    end
                end
            end

            assign aDel = aSkew_q[PRE_DELAY-1];
            assign bDel = bSkew_q[PRE_DELAY-1];
        end
    endgenerate

    // The add is one bit wider than the slice, so the carry out is simply the top bit.
    assign sumFull_d = {1'b0, aDel} + {1'b0, bDel} + {{W{1'b0}}, carry_i};

    // Register the slice sum and its carry. The next stage consumes the carry one enabled cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sumFull_d[W-1:0];
            carry_q <= sumFull_d[W];
        end
    end

    assign carry_o = carry_q;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    // The carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
    assign signOvf_o = (aDel[W-1] ^ bDel[W-1] ^ sumFull_d[W-1]) ^ sumFull_d[W];
`endif

    generate
        if (POST_DELAY == 0) begin : g_noDeskew
            assign sum_o = sum_q;
        end else begin : g_deskew
            logic [W-1:0] deskew_q [POST_DELAY];

            // Output deskew: delay this slice's sum until the highest slice of the same word completes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < POST_DELAY; i++) begin
                        deskew_q[i] <= '0;
                    end
                end else if (en) begin
                    deskew_q[0] <= sum_q;
                    for (int i = 1; i < POST_DELAY; i++) begin
                        deskew_q[i] <= deskew_q[i-1];
                    end
                end
            end

            assign sum_o = deskew_q[POST_DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into CHUNK-bit slices, one pipeline
// stage per slice. It accepts one operand pair per enabled cycle and has a
// latency of NSTAGE enabled cycles.
// Optional feature macro: PIPELINED_ADDER_OVERFLOW_EN adds a registered
// two's-complement overflow output that is aligned with out.
module pipelined_adder
    import math_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             valid_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // Guard the sizing so an illegal parameter produces the error below rather than a cascade of width errors.
    localparam int NSTAGE = (WIDTH < 1 || CHUNK < 1) ? 1 : ceil_division(WIDTH, CHUNK);

    generate
        if (WIDTH < 1) begin : g_badWidth
            $error("pipelined_adder: WIDTH must be at least 1");
        end
        if (CHUNK < 1) begin : g_badChunk
            $error("pipelined_adder: CHUNK must be at least 1");
        end
    endgenerate

    logic [NSTAGE:0]   cChain;
    logic [NSTAGE-1:0] validPipe_q;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic [NSTAGE-1:0] stageOvf;
    logic              overflow_d;
    logic              overflow_q;
`endif

    assign cChain[0] = cin;

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            localparam int WK  = chunk_width(WIDTH, CHUNK, k);
            localparam int LSB = k * CHUNK;

            adder_chunk_stage #(
                .W          (WK),
                .PRE_DELAY  (k),
                .POST_DELAY (NSTAGE - 1 - k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .a_i       (in1[LSB +: WK]),
                .b_i       (in2[LSB +: WK]),
                .carry_i   (cChain[k]),
                .sum_o     (out[LSB +: WK]),
                .carry_o   (cChain[k+1])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                ,
                .signOvf_o (stageOvf[k])
`endif
            );
        end
    endgenerate

    // The last stage has no deskew, so its registered carry is already aligned with out.
    assign carry = cChain[NSTAGE];

    // Valid pipe: valid_in travels alongside the data so valid_out marks aligned words.
    always_ff @(posedge clk) begin
        if (rst) begin
            validPipe_q <= '0;
        end else if (en) begin
            validPipe_q[0] <= valid_in;
            for (int i = 1; i < NSTAGE; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
            end
        end
    end

    assign valid_out = validPipe_q[NSTAGE-1];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow_d = stageOvf[NSTAGE-1];

    // Overflow is taken from the final stage on the same edge that registers the final carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (en) begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder.
// It drives a WIDTH=8/CHUNK=4 instance with table vectors, hand-written corner
// sequences and random traffic, and a WIDTH=1/CHUNK=4 instance for the
// single-stage case.
// Honours PIPELINED_ADDER_OVERFLOW_EN for the overflow output.
module tb_pipelined_adder;

    localparam int W   = 8;
    localparam int C   = 4;
    localparam int NST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en;
    logic         validIn;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic [W-1:0] out;
    logic         carry;
    logic         validOut;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic         overflow;
    logic         overflow1;
`endif

    logic rst1, en1, vin1, a1, b1, c1, out1, carry1, vout1;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (validIn),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out       (out),
        .carry     (carry),
        .valid_out (validOut)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    pipelined_adder #(.WIDTH(1), .CHUNK(4)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .en        (en1),
        .valid_in  (vin1),
        .in1       (a1),
        .in2       (b1),
        .cin       (c1),
        .out       (out1),
        .carry     (carry1),
        .valid_out (vout1)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow1)
`endif
    );

    // Reference model: a queue of whole-word results, indexed by enabled cycles.
    typedef struct {
        logic         valid;
        logic [W-1:0] sum;
        logic         cy;
        logic         ovf;
        logic         chk;
    } expEntry_t;

    expEntry_t pipeQ[$];
    expEntry_t expCur;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] expOut;
        logic         expCy;
        logic         expOvf;
    } vec_t;

    vec_t vecs[4];

    function automatic expEntry_t blankEntry();
        expEntry_t e;
        e.valid = 1'b0;
        e.sum   = '0;
        e.cy    = 1'b0;
        e.ovf   = 1'b0;
        e.chk   = 1'b0;
        return e;
    endfunction

    function automatic expEntry_t computeEntry(input logic v, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic c);
        expEntry_t e;
        int        u;
        int        sa;
        int        sb;
        int        r;
        u  = int'(a) + int'(b) + int'(c);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa + sb + int'(c);
        e.valid = v;
        e.sum   = u[W-1:0];
        e.cy    = u[W];
        e.ovf   = (r > 127) || (r < -128);
        e.chk   = v;
        return e;
    endfunction

    task automatic modelReset();
        pipeQ.delete();
        for (int i = 0; i < NST - 1; i++) pipeQ.push_back(blankEntry());
        expCur     = blankEntry();
        expCur.chk = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle, advance the model and compare the DUT against it.
    task automatic applyStimulus(input logic e, input logic v, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
        en      = e;
        validIn = v;
        in1     = a;
        in2     = b;
        cin     = c;
        @(posedge clk);
        #1;
        if (rst) begin
            modelReset();
        end else if (e) begin
            pipeQ.push_back(computeEntry(v, a, b, c));
            expCur = pipeQ.pop_front();
        end
        checkOutput("model valid_out", {31'b0, validOut}, {31'b0, expCur.valid});
        if (expCur.chk) begin
            checkOutput("model out", {24'b0, out}, {24'b0, expCur.sum});
            checkOutput("model carry", {31'b0, carry}, {31'b0, expCur.cy});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            checkOutput("model overflow", {31'b0, overflow}, {31'b0, expCur.ovf});
`endif
        end
    endtask

    task automatic checkWord(input string name, input logic [W-1:0] eo, input logic ec,
                             input logic eovf);
        checkOutput({name, " valid_out"}, {31'b0, validOut}, 32'd1);
        checkOutput({name, " out"}, {24'b0, out}, {24'b0, eo});
        checkOutput({name, " carry"}, {31'b0, carry}, {31'b0, ec});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        checkOutput({name, " overflow"}, {31'b0, overflow}, {31'b0, eovf});
`else
        if (eovf === 1'bx) $display("[TB] note: unknown overflow expectation");
`endif
    endtask

    initial begin
        vecs[0] = '{a: 8'h0F, b: 8'h01, c: 1'b0, expOut: 8'h10, expCy: 1'b0, expOvf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h00, c: 1'b1, expOut: 8'h00, expCy: 1'b1, expOvf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, c: 1'b0, expOut: 8'h80, expCy: 1'b0, expOvf: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, expOut: 8'h00, expCy: 1'b1, expOvf: 1'b1};

        rst  = 1'b1;
        rst1 = 1'b1;
        en1  = 1'b1;
        vin1 = 1'b0;
        a1   = 1'b0;
        b1   = 1'b0;
        c1   = 1'b0;
        modelReset();

        // Reset with en low: reset has priority over the enable.
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("reset out", {24'b0, out}, 32'd0);
        checkOutput("reset valid_out", {31'b0, validOut}, 32'd0);
        rst  = 1'b0;
        rst1 = 1'b0;
        en1  = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("[TB] table vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            checkOutput("table early valid", {31'b0, validOut}, 32'd0);
            applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            checkWord($sformatf("table[%0d]", i), vecs[i].expOut, vecs[i].expCy, vecs[i].expOvf);
            applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput("table single-cycle valid", {31'b0, validOut}, 32'd0);
        end

        $display("[TB] streaming");
        applyStimulus(1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hF0, 8'h20, 1'b0);
        checkWord("stream0", 8'h46, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
        checkWord("stream1", 8'h10, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        checkWord("stream2", 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("[TB] stall");
        applyStimulus(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput("stall valid_out", {31'b0, validOut}, 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        checkWord("stall result", 8'h80, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b1, 1'b1, 8'hAA, 8'h55, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("midreset out", {24'b0, out}, 32'd0);
        checkOutput("midreset carry", {31'b0, carry}, 32'd0);
        checkOutput("midreset valid_out", {31'b0, validOut}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput("post-reset no stale valid", {31'b0, validOut}, 32'd0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(($urandom_range(0, 9) < 8), 1'($urandom), 8'($urandom),
                          8'($urandom), 1'($urandom));
        end
        rst = 1'b0;

        $display("[TB] single-stage WIDTH=1");
        en1  = 1'b1;
        vin1 = 1'b1;
        a1   = 1'b1;
        b1   = 1'b1;
        c1   = 1'b1;
        @(posedge clk);
        #1;
        vin1 = 1'b0;
        a1   = 1'b0;
        b1   = 1'b0;
        c1   = 1'b0;
        checkOutput("w1 out", {31'b0, out1}, 32'd1);
        checkOutput("w1 carry", {31'b0, carry1}, 32'd1);
        checkOutput("w1 valid_out", {31'b0, vout1}, 32'd1);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        checkOutput("w1 overflow", {31'b0, overflow1}, 32'd0);
`endif
        @(posedge clk);
        #1;
        checkOutput("w1 valid drop", {31'b0, vout1}, 32'd0);
        checkOutput("w1 out zero", {31'b0, out1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
